// File: rtl/bnn_pkg.sv
// Shared phase encoding and error codes for the BNN inference pipeline.
// The register bank and layer engines decode the same phase values.
package bnn_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_LOAD    = 3'b001,
        S_LAYER_1 = 3'b010,
        S_LAYER_2 = 3'b011,
        S_LAYER_3 = 3'b100,
        S_DONE    = 3'b101,
        S_ERR     = 3'b110
    } phase_t;

    localparam logic [1:0] E_LOAD = 2'd0;
    localparam logic [1:0] E_L1   = 2'd1;
    localparam logic [1:0] E_L2   = 2'd2;
    localparam logic [1:0] E_L3   = 2'd3;

    localparam int LOAD_BITS = 3104;

endpackage

// File: rtl/bnn_watchdog.sv
// Per-phase cycle counter. Flags expiry on the cycle whose edge would bring
// the count up to the limit.
module bnn_watchdog #(
    parameter int TMO_W = 13
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [TMO_W-1:0] limit,
    output logic             expired
);

    logic [TMO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == limit - 1'b1);

endmodule

// File: rtl/bnn_sequencer.sv
// Phase controller for the BNN pipeline: load, three layers, class latch,
// and a sticky watchdog trap for hung phases.
module bnn_sequencer
    import bnn_pkg::*;
#(
    parameter int LOAD_TMO  = 4096,
    parameter int LAYER_TMO = 1024,
    parameter int TMO_W     = 13
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       load_done,
    input  logic       l1_done,
    input  logic       l2_done,
    input  logic       l3_done,
    input  logic [3:0] class_in,
    output logic [2:0] state,
    output logic       l1_start,
    output logic       l2_start,
    output logic       l3_start,
    output logic       busy,
    output logic       done,
    output logic [3:0] class_out,
    output logic       error,
    output logic [1:0] err_code
);

    phase_t           state_q;
    logic             l1_ok, l2_ok, l3_ok;
    logic             wd_clear, wd_en, wd_expired;
    logic [TMO_W-1:0] wd_limit;

    // The start pulse doubles as the first-cycle marker, so a done that
    // arrives together with its own start is never accepted.
    always_comb begin
        l1_ok    = (state_q == S_LAYER_1) && l1_done && !l1_start;
        l2_ok    = (state_q == S_LAYER_2) && l2_done && !l2_start;
        l3_ok    = (state_q == S_LAYER_3) && l3_done && !l3_start;
        wd_en    = (state_q == S_LOAD) || (state_q == S_LAYER_1) ||
                   (state_q == S_LAYER_2) || (state_q == S_LAYER_3);
        wd_limit = (state_q == S_LOAD) ? TMO_W'(LOAD_TMO) : TMO_W'(LAYER_TMO);
        wd_clear = 1'b0;
        case (state_q)
            S_IDLE:    wd_clear = start;
            S_LOAD:    wd_clear = load_done || wd_expired;
            S_LAYER_1: wd_clear = l1_ok || wd_expired;
            S_LAYER_2: wd_clear = l2_ok || wd_expired;
            S_LAYER_3: wd_clear = l3_ok || wd_expired;
            S_DONE:    wd_clear = 1'b1;
            default:   wd_clear = 1'b0;
        endcase
    end

    bnn_watchdog #(.TMO_W(TMO_W)) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (wd_clear),
        .enable  (wd_en),
        .limit   (wd_limit),
        .expired (wd_expired)
    );

    // Completion is tested before expiry in every phase so a coincident done wins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            l1_start  <= 1'b0;
            l2_start  <= 1'b0;
            l3_start  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            class_out <= 4'd0;
            error     <= 1'b0;
            err_code  <= E_LOAD;
        end else begin
            l1_start <= 1'b0;
            l2_start <= 1'b0;
            l3_start <= 1'b0;
            done     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (load_done) begin
                            state_q  <= S_LAYER_1;
                            l1_start <= 1'b1;
                        end else begin
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (load_done) begin
                        state_q  <= S_LAYER_1;
                        l1_start <= 1'b1;
                    end else if (wd_expired) begin
                        state_q  <= S_ERR;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                        err_code <= E_LOAD;
                    end
                end
                S_LAYER_1: begin
                    if (l1_ok) begin
                        state_q  <= S_LAYER_2;
                        l2_start <= 1'b1;
                    end else if (wd_expired) begin
                        state_q  <= S_ERR;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                        err_code <= E_L1;
                    end
                end
                S_LAYER_2: begin
                    if (l2_ok) begin
                        state_q  <= S_LAYER_3;
                        l3_start <= 1'b1;
                    end else if (wd_expired) begin
                        state_q  <= S_ERR;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                        err_code <= E_L2;
                    end
                end
                S_LAYER_3: begin
                    if (l3_ok) begin
                        state_q   <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        class_out <= class_in;
                    end else if (wd_expired) begin
                        state_q  <= S_ERR;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                        err_code <= E_L3;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                S_ERR: begin
                    state_q <= S_ERR;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_bnn_sequencer.sv
// Directed bench for bnn_sequencer, built with a 16-cycle layer timeout.
module tb_bnn_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       load_done = 1'b0;
    logic       l1_done = 1'b0;
    logic       l2_done = 1'b0;
    logic       l3_done = 1'b0;
    logic [3:0] class_in = 4'd0;
    logic [2:0] state;
    logic       l1_start, l2_start, l3_start;
    logic       busy, done, error;
    logic [3:0] class_out;
    logic [1:0] err_code;

    int total = 0;
    int passed = 0;

    bnn_sequencer #(.LOAD_TMO(4096), .LAYER_TMO(16), .TMO_W(13)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .load_done (load_done),
        .l1_done   (l1_done),
        .l2_done   (l2_done),
        .l3_done   (l3_done),
        .class_in  (class_in),
        .state     (state),
        .l1_start  (l1_start),
        .l2_start  (l2_start),
        .l3_start  (l3_start),
        .busy      (busy),
        .done      (done),
        .class_out (class_out),
        .error     (error),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    // Observe on the falling edge: pulse counts and the state-change log.
    int         l1_cnt = 0, l2_cnt = 0, l3_cnt = 0, done_cnt = 0;
    logic [2:0] last_state = 3'b000;
    logic [2:0] slog[$];

    always @(negedge clk) begin
        if (state !== last_state) slog.push_back(state);
        last_state <= state;
        if (l1_start) l1_cnt <= l1_cnt + 1;
        if (l2_start) l2_cnt <= l2_cnt + 1;
        if (l3_start) l3_cnt <= l3_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Wait dly cycles in the current layer, then pulse that layer's done.
    task automatic fire(input int which, input int dly, input logic [3:0] cls);
        repeat (dly) tick();
        case (which)
            1: l1_done = 1'b1;
            2: l2_done = 1'b1;
            default: begin l3_done = 1'b1; class_in = cls; end
        endcase
        tick();
        l1_done = 1'b0;
        l2_done = 1'b0;
        l3_done = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        total++;
        if ({state, l1_start, l2_start, l3_start, busy, done, error, class_out, err_code} !== 16'h0) begin
            $display("FAIL reset_outputs: got state=%b starts=%b%b%b busy=%b done=%b error=%b class=%0d code=%0d, want all zero",
                     state, l1_start, l2_start, l3_start, busy, done, error, class_out, err_code);
        end else passed++;
        reset_n = 1'b1;
    endtask

    task automatic test_cold_run();
        int lb, sb1, sb2, sb3, db, bad;
        logic [17:0] seq;
        lb = slog.size(); sb1 = l1_cnt; sb2 = l2_cnt; sb3 = l3_cnt; db = done_cnt;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (state !== 3'b001 || busy !== 1'b1) begin
            $display("FAIL cold_load_entry: got state=%b busy=%b, want 001/1", state, busy);
        end else passed++;
        bad = 0;
        for (int i = 0; i < 3103; i++) begin
            tick();
            if (state !== 3'b001) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL cold_load_hold: got %0d cycles out of LOAD, want 0", bad);
        else passed++;
        load_done = 1'b1;
        tick();
        total++;
        if (state !== 3'b010 || l1_start !== 1'b1) begin
            $display("FAIL cold_l1_entry: got state=%b l1_start=%b, want 010/1", state, l1_start);
        end else passed++;
        fire(1, 5, 4'd0);
        fire(2, 5, 4'd0);
        fire(3, 10, 4'd7);
        total++;
        if (done !== 1'b1 || class_out !== 4'd7 || state !== 3'b101) begin
            $display("FAIL cold_done: got done=%b class=%0d state=%b, want 1/7/101", done, class_out, state);
        end else passed++;
        repeat (4) tick();
        seq = 18'h0;
        for (int i = 0; i < 6; i++) if (lb + i < slog.size()) seq = {seq[14:0], slog[lb + i]};
        total++;
        if (slog.size() - lb != 6 || seq !== 18'o123450) begin
            $display("FAIL cold_sequence: got %0d changes seq=%o, want 6 changes seq=123450", slog.size() - lb, seq);
        end else passed++;
        total++;
        if (l1_cnt - sb1 != 1 || l2_cnt - sb2 != 1 || l3_cnt - sb3 != 1 || done_cnt - db != 1) begin
            $display("FAIL cold_pulses: got l1=%0d l2=%0d l3=%0d done=%0d, want 1 each",
                     l1_cnt - sb1, l2_cnt - sb2, l3_cnt - sb3, done_cnt - db);
        end else passed++;
        total++;
        if (class_out !== 4'd7 || state !== 3'b000) begin
            $display("FAIL cold_hold: got class=%0d state=%b, want 7/000", class_out, state);
        end else passed++;
    endtask

    task automatic test_warm_run();
        int db;
        db = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (state !== 3'b010 || l1_start !== 1'b1) begin
            $display("FAIL warm_direct_l1: got state=%b l1_start=%b, want 010/1", state, l1_start);
        end else passed++;
        fire(1, 1, 4'd0);
        fire(2, 1, 4'd0);
        fire(3, 1, 4'd9);
        total++;
        if (done !== 1'b1 || done_cnt != db || class_out !== 4'd9) begin
            $display("FAIL warm_latency: got done=%b earlier_dones=%0d class=%0d, want 1/0/9",
                     done, done_cnt - db, class_out);
        end else passed++;
        tick();
    endtask

    task automatic test_spurious();
        start = 1'b1;
        tick();
        start = 1'b0;
        l1_done = 1'b1;
        l3_done = 1'b1;
        class_in = 4'd15;
        tick();
        l1_done = 1'b0;
        l3_done = 1'b0;
        total++;
        if (state !== 3'b010 || l2_start !== 1'b0 || class_out !== 4'd9) begin
            $display("FAIL spurious_l1: got state=%b l2_start=%b class=%0d, want 010/0/9", state, l2_start, class_out);
        end else passed++;
        fire(1, 0, 4'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (state !== 3'b011 || l1_start !== 1'b0) begin
            $display("FAIL start_in_l2: got state=%b l1_start=%b, want 011/0", state, l1_start);
        end else passed++;
        fire(2, 0, 4'd0);
        fire(3, 1, 4'd4);
        total++;
        if (class_out !== 4'd4 || done !== 1'b1) begin
            $display("FAIL spurious_finish: got class=%0d done=%b, want 4/1", class_out, done);
        end else passed++;
        tick();
    endtask

    task automatic test_coincidence();
        start = 1'b1;
        tick();
        start = 1'b0;
        fire(1, 15, 4'd0);
        total++;
        if (state !== 3'b011 || error !== 1'b0 || l2_start !== 1'b1) begin
            $display("FAIL coincidence: got state=%b error=%b l2_start=%b, want 011/0/1", state, error, l2_start);
        end else passed++;
    endtask

    // Continues from LAYER_2 entry left by test_coincidence.
    task automatic test_watchdog();
        repeat (15) tick();
        total++;
        if (state !== 3'b011 || error !== 1'b0) begin
            $display("FAIL wd_before: got state=%b error=%b, want 011/0", state, error);
        end else passed++;
        tick();
        total++;
        if (state !== 3'b110 || error !== 1'b1 || err_code !== 2'd2 || busy !== 1'b0) begin
            $display("FAIL wd_trip: got state=%b error=%b code=%0d busy=%b, want 110/1/2/0", state, error, err_code, busy);
        end else passed++;
        start = 1'b1; l2_done = 1'b1; l3_done = 1'b1;
        repeat (3) tick();
        start = 1'b0; l2_done = 1'b0; l3_done = 1'b0;
        total++;
        if (state !== 3'b110 || error !== 1'b1 || err_code !== 2'd2) begin
            $display("FAIL wd_sticky: got state=%b error=%b code=%0d, want 110/1/2", state, error, err_code);
        end else passed++;
        reset_n = 1'b0;
        tick();
        total++;
        if (state !== 3'b000 || error !== 1'b0 || err_code !== 2'd0) begin
            $display("FAIL wd_reset: got state=%b error=%b code=%0d, want 000/0/0", state, error, err_code);
        end else passed++;
        reset_n = 1'b1;
        load_done = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4095) tick();
        total++;
        if (state !== 3'b001) $display("FAIL wd_load_before: got state=%b, want 001", state);
        else passed++;
        tick();
        total++;
        if (state !== 3'b110 || error !== 1'b1 || err_code !== 2'd0) begin
            $display("FAIL wd_load_trip: got state=%b error=%b code=%0d, want 110/1/0", state, error, err_code);
        end else passed++;
        load_done = 1'b1;
        do_reset();
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        tick();
        fire(1, 1, 4'd0);
        fire(2, 1, 4'd0);
        fire(3, 1, 4'd3);
        tick();
        total++;
        if (state !== 3'b000 || done !== 1'b0) begin
            $display("FAIL b2b_idle: got state=%b done=%b, want 000/0", state, done);
        end else passed++;
        tick();
        start = 1'b0;
        total++;
        if (state !== 3'b010 || l1_start !== 1'b1 || class_out !== 4'd3) begin
            $display("FAIL b2b_restart: got state=%b l1_start=%b class=%0d, want 010/1/3", state, l1_start, class_out);
        end else passed++;
        fire(1, 1, 4'd0);
        fire(2, 1, 4'd0);
        tick();
    endtask

    // Continues from the second cycle of LAYER_3 left by test_back_to_back.
    task automatic test_midop_reset();
        int db;
        db = done_cnt;
        reset_n = 1'b0;
        l3_done = 1'b1;
        class_in = 4'd11;
        tick();
        reset_n = 1'b1;
        l3_done = 1'b0;
        total++;
        if (state !== 3'b000 || busy !== 1'b0 || class_out !== 4'd0 || done !== 1'b0) begin
            $display("FAIL midop_reset: got state=%b busy=%b class=%0d done=%b, want 000/0/0/0", state, busy, class_out, done);
        end else passed++;
        repeat (2) tick();
        total++;
        if (done_cnt != db || state !== 3'b000) begin
            $display("FAIL midop_no_done: got %0d done pulses state=%b, want 0/000", done_cnt - db, state);
        end else passed++;
    endtask

    initial begin
        test_reset();
        test_cold_run();
        test_warm_run();
        test_spurious();
        test_coincidence();
        test_watchdog();
        test_back_to_back();
        test_midop_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
